// File: rtl/lap_buffer.sv
// -----------------------------------------------------------------------------
// lap_buffer
// Stopwatch lap memory. It records live time snapshots on lap-button edges
// into a DEPTH-slot ring. A recall button lets the user browse the stored laps,
// newest first, and then returns to the live time.
//
// Ports
//   clk_100Hz            100 Hz timing clock (the same clock as the stopwatch counter)
//   rst_n                asynchronous active-low reset
//   lap/recall/clear     debounced button levels; only rising edges act
//   running              stopwatch is counting; lap records are taken only then
//   *_in                 live time, four bytes, stored verbatim
//   *_out                time sent to the display (live, or the selected lap)
//   browsing             a stored lap is being shown
//   lap_idx              ordinal of the shown lap, 0 = oldest retained
//   lap_count            number of valid slots, 0..DEPTH
//   full                 lap_count == DEPTH
//
// Configuration macro
//   LAP_OVERWRITE_EN     defined:   a lap while full overwrites the oldest slot
//                        undefined: a lap while full is dropped
// -----------------------------------------------------------------------------
module lap_buffer #(
    parameter int DEPTH = 8
) (
    input  logic       clk_100Hz,
    input  logic       rst_n,
    input  logic       lap,
    input  logic       recall,
    input  logic       clear,
    input  logic       running,
    input  logic [7:0] hours_in,
    input  logic [7:0] minutes_in,
    input  logic [7:0] seconds_in,
    input  logic [7:0] centisec_in,
    output logic [7:0] hours_out,
    output logic [7:0] minutes_out,
    output logic [7:0] seconds_out,
    output logic [7:0] centisec_out,
    output logic       browsing,
    output logic [3:0] lap_idx,
    output logic [4:0] lap_count,
    output logic       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {ST_LIVE, ST_BROWSE} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_lap_prev, r_rec_prev, r_clr_prev;
    logic            w_lap_edge, w_rec_edge, w_clr_edge;
    logic [AW-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [AW-1:0]   r_rd_ptr, w_rd_ptr_nxt;
    logic [AW-1:0]   w_oldest;
    logic [4:0]      r_count, w_count_nxt;
    logic [3:0]      r_idx, w_idx_nxt;
    logic            w_full;
    logic            w_we;
    logic [31:0]     w_live;
    logic [31:0]     r_out;
    logic [31:0]     r_mem [DEPTH];

    assign w_live     = {hours_in, minutes_in, seconds_in, centisec_in};
    assign w_lap_edge = lap    & ~r_lap_prev;
    assign w_rec_edge = recall & ~r_rec_prev;
    assign w_clr_edge = clear  & ~r_clr_prev;
    assign w_full     = (r_count == 5'(DEPTH));
    // When full, the low bits of lap_count wrap to 0. Then oldest == wr_ptr,
    // which is the correct oldest slot.
    assign w_oldest   = r_wr_ptr - r_count[AW-1:0];

    // The prev registers reset to 1. A button held through reset release
    // therefore looks like "already high" and produces no edge.
    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_prev <= 1'b1;
            r_rec_prev <= 1'b1;
            r_clr_prev <= 1'b1;
        end else begin
            r_lap_prev <= lap;
            r_rec_prev <= recall;
            r_clr_prev <= clear;
        end
    end

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_LIVE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

    // Priority: clear, then lap, then recall.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        w_idx_nxt    = r_idx;
        w_we         = 1'b0;
        if (w_clr_edge) begin
            w_state_nxt  = ST_LIVE;
            w_wr_ptr_nxt = '0;
            w_count_nxt  = '0;
            w_idx_nxt    = '0;
        end else begin
            case (r_state)
                ST_LIVE: begin
                    if (w_lap_edge && running) begin
                        if (!w_full) begin
                            w_we         = 1'b1;
                            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                            w_count_nxt  = r_count + 5'd1;
                        end
`ifdef LAP_OVERWRITE_EN
                        else begin
                            w_we         = 1'b1;
                            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                        end
`endif
                    end else if (w_rec_edge && r_count != 5'd0) begin
                        w_state_nxt = ST_BROWSE;
                        w_idx_nxt   = 4'(r_count - 5'd1);
                    end
                end
                ST_BROWSE: begin
                    if (w_lap_edge) begin
                        w_state_nxt = ST_LIVE;
                        w_idx_nxt   = '0;
                    end else if (w_rec_edge) begin
                        if (r_idx == 4'd0) begin
                            w_state_nxt = ST_LIVE;
                        end else begin
                            w_idx_nxt = r_idx - 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_LIVE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
        // wr_ptr and lap_count do not change while browsing, so oldest_ptr
        // taken from the current registers is valid for the next slot.
        w_rd_ptr_nxt = (w_state_nxt == ST_BROWSE) ? (w_oldest + w_idx_nxt[AW-1:0]) : '0;
    end

    // Slot storage has no reset, because clear does not need to erase it.
    // Writes are qualified by edges, and edges cannot fire while reset holds
    // the prev registers at 1.
    always_ff @(posedge clk_100Hz) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= w_live;
        end
    end

    // The output register loads the slot selected for the next state. A
    // recalled lap therefore appears together with browsing=1.
    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_state_nxt == ST_BROWSE) begin
            r_out <= r_mem[w_rd_ptr_nxt];
        end else begin
            r_out <= w_live;
        end
    end

    assign hours_out    = r_out[31:24];
    assign minutes_out  = r_out[23:16];
    assign seconds_out  = r_out[15:8];
    assign centisec_out = r_out[7:0];
    assign browsing     = (r_state == ST_BROWSE);
    assign lap_idx      = r_idx;
    assign lap_count    = r_count;
    assign full         = w_full;

endmodule

// File: tb/tb_lap_buffer.sv
module tb_lap_buffer;

    localparam int DEPTH = 8;
    localparam int B_LAP = 0;
    localparam int B_REC = 1;
    localparam int B_CLR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lap = 1'b1;
    logic       recall = 1'b0;
    logic       clear = 1'b0;
    logic       running = 1'b0;
    logic [7:0] hi = 8'h00, mi = 8'h00, si = 8'h00, ci = 8'h00;
    logic [7:0] ho, mo, so, co;
    logic       browsing, full;
    logic [3:0] lap_idx;
    logic [4:0] lap_count;

    lap_buffer #(.DEPTH(DEPTH)) dut (
        .clk_100Hz   (clk),
        .rst_n       (rst_n),
        .lap         (lap),
        .recall      (recall),
        .clear       (clear),
        .running     (running),
        .hours_in    (hi),
        .minutes_in  (mi),
        .seconds_in  (si),
        .centisec_in (ci),
        .hours_out   (ho),
        .minutes_out (mo),
        .seconds_out (so),
        .centisec_out(co),
        .browsing    (browsing),
        .lap_idx     (lap_idx),
        .lap_count   (lap_count),
        .full        (full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: the ordered list of retained laps (oldest first),
    // plus the browse cursor and the value the display should show.
    logic [31:0] q[$];
    bit          m_brw;
    int          m_idx;
    logic [31:0] m_out;
    bit          pl, pr, pc;
    bit          chk_en = 1'b0;
    bit          adv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_brw = 1'b0;
        m_idx = 0;
        m_out = '0;
        pl = 1'b1;
        pr = 1'b1;
        pc = 1'b1;
    endtask

    task automatic model_tick();
        bit le, re, ce;
        logic [31:0] li;
        li = {hi, mi, si, ci};
        le = lap && !pl;
        re = recall && !pr;
        ce = clear && !pc;
        pl = lap;
        pr = recall;
        pc = clear;
        if (ce) begin
            q.delete();
            m_brw = 1'b0;
            m_idx = 0;
            m_out = li;
        end else if (!m_brw) begin
            m_out = li;
            if (le && running) begin
                if (q.size() < DEPTH) q.push_back(li);
`ifdef LAP_OVERWRITE_EN
                else begin
                    void'(q.pop_front());
                    q.push_back(li);
                end
`endif
            end else if (re && q.size() > 0) begin
                m_brw = 1'b1;
                m_idx = q.size() - 1;
                m_out = q[m_idx];
            end
        end else begin
            if (le) begin
                m_brw = 1'b0;
                m_idx = 0;
                m_out = li;
            end else if (re) begin
                if (m_idx == 0) begin
                    m_brw = 1'b0;
                    m_out = li;
                end else begin
                    m_idx--;
                    m_out = q[m_idx];
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out", {ho, mo, so, co}, m_out);
            chk("browsing", 32'(browsing), 32'(m_brw));
            chk("lap_idx", 32'(lap_idx), m_brw ? m_idx : 0);
            chk("lap_count", 32'(lap_count), q.size());
            chk("full", 32'(full), 32'(q.size() == DEPTH));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_tick();
        #1;
        if (adv) ci = ci + 8'd1;
    endtask

    task automatic press(input int which);
        case (which)
            B_LAP:   lap = 1'b1;
            B_REC:   recall = 1'b1;
            default: clear = 1'b1;
        endcase
        cyc();
        lap = 1'b0;
        recall = 1'b0;
        clear = 1'b0;
        cyc();
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic [7:0] c);
        hi = h;
        mi = m;
        si = s;
        ci = c;
    endtask

    task automatic rec_lap(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic [7:0] c);
        set_time(h, m, s, c);
        press(B_LAP);
    endtask

    initial begin
        model_reset();
        // The lap button is held through reset release. It must not record.
        repeat (2) @(posedge clk);
        #1;
        chk("rst out", {ho, mo, so, co}, 32'h0);
        chk("rst browsing", 32'(browsing), 32'h0);
        chk("rst lap_idx", 32'(lap_idx), 32'h0);
        chk("rst lap_count", 32'(lap_count), 32'h0);
        chk("rst full", 32'(full), 32'h0);
        running = 1'b1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        cyc();
        cyc();
        lap = 1'b0;
        cyc();
        cyc();
        chk("held lap count", 32'(lap_count), 32'd0);

        // A single lap, recalled and held while the inputs advance.
        rec_lap(8'h00, 8'h00, 8'h05, 8'h20);
        chk("one lap count", 32'(lap_count), 32'd1);
        press(B_REC);
        chk("recall browsing", 32'(browsing), 32'd1);
        chk("recall idx", 32'(lap_idx), 32'd0);
        chk("recall out", {ho, mo, so, co}, 32'h00000520);
        adv = 1'b1;
        repeat (5) cyc();
        adv = 1'b0;
        chk("held out", {ho, mo, so, co}, 32'h00000520);
        press(B_REC);
        set_time(8'h01, 8'h02, 8'h03, 8'h04);
        cyc();
        cyc();
        chk("live tracking", {ho, mo, so, co}, 32'h01020304);
        chk("live browsing", 32'(browsing), 32'd0);

        // Three laps A, B, C, walked newest to oldest and then back to live.
        press(B_CLR);
        rec_lap(8'h00, 8'h01, 8'h00, 8'h11);
        rec_lap(8'h00, 8'h02, 8'h00, 8'h22);
        rec_lap(8'h00, 8'h03, 8'h00, 8'h33);
        press(B_REC);
        chk("C idx", 32'(lap_idx), 32'd2);
        chk("C out", {ho, mo, so, co}, 32'h00030033);
        press(B_REC);
        chk("B idx", 32'(lap_idx), 32'd1);
        chk("B out", {ho, mo, so, co}, 32'h00020022);
        press(B_REC);
        chk("A idx", 32'(lap_idx), 32'd0);
        chk("A out", {ho, mo, so, co}, 32'h00010011);
        press(B_REC);
        chk("exit browsing", 32'(browsing), 32'd0);
        set_time(8'h00, 8'h04, 8'h00, 8'h44);
        cyc();
        chk("exit tracking", {ho, mo, so, co}, 32'h00040044);

        // Nine laps into eight slots.
        press(B_CLR);
        for (int k = 1; k <= 9; k++) rec_lap(8'h00, 8'h00, 8'(k), 8'h11);
        chk("full count", 32'(lap_count), 32'd8);
        chk("full flag", 32'(full), 32'd1);
        press(B_REC);
        chk("newest idx", 32'(lap_idx), 32'd7);
`ifdef LAP_OVERWRITE_EN
        chk("newest out", {ho, mo, so, co}, 32'h00000911);
`else
        chk("newest out", {ho, mo, so, co}, 32'h00000811);
`endif
        repeat (7) press(B_REC);
        chk("oldest idx", 32'(lap_idx), 32'd0);
`ifdef LAP_OVERWRITE_EN
        chk("oldest out", {ho, mo, so, co}, 32'h00000211);
`else
        chk("oldest out", {ho, mo, so, co}, 32'h00000111);
`endif
        press(B_REC);

        // Simultaneous edges.
        press(B_CLR);
        for (int k = 1; k <= 3; k++) rec_lap(8'h02, 8'h00, 8'(k), 8'h00);
        chk("three count", 32'(lap_count), 32'd3);
        lap = 1'b1;
        clear = 1'b1;
        cyc();
        lap = 1'b0;
        clear = 1'b0;
        cyc();
        chk("lap+clear count", 32'(lap_count), 32'd0);
        chk("lap+clear browsing", 32'(browsing), 32'd0);
        set_time(8'h03, 8'h00, 8'h00, 8'h07);
        lap = 1'b1;
        recall = 1'b1;
        cyc();
        lap = 1'b0;
        recall = 1'b0;
        cyc();
        chk("lap+recall count", 32'(lap_count), 32'd1);
        chk("lap+recall browsing", 32'(browsing), 32'd0);

        // A lap while stopped is ignored.
        running = 1'b0;
        press(B_LAP);
        chk("stopped lap count", 32'(lap_count), 32'd1);
        running = 1'b1;

        // A lap pressed while browsing returns to live and records nothing.
        press(B_REC);
        chk("browse again", 32'(browsing), 32'd1);
        chk("browse again out", {ho, mo, so, co}, 32'h03000007);
        press(B_LAP);
        chk("lap exits browse", 32'(browsing), 32'd0);
        chk("lap exits count", 32'(lap_count), 32'd1);

        // Reset asserted in the middle of browsing takes effect at once.
        press(B_REC);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst browsing", 32'(browsing), 32'd0);
        chk("midrst count", 32'(lap_count), 32'd0);
        chk("midrst out", {ho, mo, so, co}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk_en = 1'b1;
        rec_lap(8'h05, 8'h06, 8'h07, 8'h08);
        press(B_REC);
        chk("post rst out", {ho, mo, so, co}, 32'h05060708);
        repeat (3) cyc();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
